axi_user_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single AXI user interface (start/rw/addr/wdata/wvalid/wready/rdata/done/busy). It sits between the instruction-fetch and MEM-stage requesters and the AXI master. Grants one requester at a time and drives a single transaction through the issue, write-data and completion phases. Returns completion and read data to the owning requester only.

---
 rtl/axi_user_arbiter.sv | 111 +++++++++++
 tb/tb_axi_user_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_user_arbiter.sv
// Arbitrates inst-fetch and data requesters onto one AXI user port and sequences each transaction.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority, data over inst.
//
// state | meaning
// IDLE  | waiting for a request while the AXI master is not busy
// WDATA | store in flight, axi_wvalid held until axi_wready
// WAIT  | waiting for axi_done
// RESP  | owner's done pulse is high
module axi_user_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        axi_start,
  output logic        axi_rw,
  output logic [31:0] axi_addr,
  output logic [31:0] axi_wdata,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_done,
  input  logic        axi_busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;

  state_t state;
  logic   grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // owner always holds the last grant and resets to inst, so data wins the first tie
  assign grant_d = d_req & (~i_req | ~owner);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      axi_start  <= 1'b0;
      axi_rw     <= 1'b0;
      axi_addr   <= 32'h0;
      axi_wdata  <= 32'h0;
      axi_wvalid <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
      owner      <= 1'b0;
    end else begin
      axi_start <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      case (state)
        IDLE: begin
          if ((i_req | d_req) && !axi_busy) begin
            axi_start <= 1'b1;
            owner     <= grant_d;
            if (grant_d) begin
              axi_addr   <= d_addr;
              axi_rw     <= d_rw;
              axi_wdata  <= d_wdata;
              axi_wvalid <= ~d_rw;
              state      <= d_rw ? WAIT : WDATA;
            end else begin
              axi_addr <= i_addr;
              axi_rw   <= 1'b1;
              state    <= WAIT;
            end
          end
        end
        WDATA: begin
          // a done seen before wready is ignored; one seen with wready completes the store
          if (axi_wready) begin
            axi_wvalid <= 1'b0;
            if (axi_done) begin
              i_done <= ~owner;
              d_done <= owner;
              state  <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (axi_done) begin
            if (axi_rw) begin
              if (owner) d_rdata <= axi_rdata;
              else       i_rdata <= axi_rdata;
            end
            i_done <= ~owner;
            d_done <= owner;
            state  <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Self-checking bench for axi_user_arbiter: directed cases plus randomized traffic against a
// transaction-level model of grant order, latched fields and returned read data.
module tb_axi_user_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        axi_start;
  logic        axi_rw;
  logic [31:0] axi_addr;
  logic [31:0] axi_wdata;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_rdata;
  logic        axi_done;
  logic        axi_busy;
  logic        owner;

  int checks = 0;
  int errors = 0;

  // model state: last winner, read data each requester should hold, last latched wdata
  bit          m_last;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;
  logic [31:0] m_wdata;

  axi_user_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_done     (i_done),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_rw       (d_rw),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .axi_start  (axi_start),
    .axi_rw     (axi_rw),
    .axi_addr   (axi_addr),
    .axi_wdata  (axi_wdata),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_rdata  (axi_rdata),
    .axi_done   (axi_done),
    .axi_busy   (axi_busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 1 = data wins
  function automatic bit pick(input logic ir, input logic dr, input bit last);
    if (dr && !ir) return 1'b1;
    if (ir && !dr) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !last;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, axi_start, 0);
    chk({tag, "_rw"}, axi_rw, 0);
    chk({tag, "_addr"}, axi_addr, 0);
    chk({tag, "_wdata"}, axi_wdata, 0);
    chk({tag, "_wvalid"}, axi_wvalid, 0);
    chk({tag, "_dones"}, {i_done, d_done}, 0);
    chk({tag, "_irdata"}, i_rdata, 0);
    chk({tag, "_drdata"}, d_rdata, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  // Called during a cycle in which the DUT is idle with requests already driven.
  // wl: cycles wvalid stays high (stores); dl: cycles in the completion wait; combo: done with wready.
  task automatic serve(input int wl, input int dl, input bit combo, input logic [31:0] rd);
    bit          w;
    bit          store;
    logic [31:0] ea;
    w     = pick(i_req, d_req, m_last);
    store = w && !d_rw;
    ea    = w ? d_addr : i_addr;
    if (w) m_wdata = d_wdata;
    tick;
    chk("start", axi_start, 1);
    chk("rw", axi_rw, w ? {31'b0, d_rw} : 32'd1);
    chk("addr", axi_addr, ea);
    chk("wdata", axi_wdata, m_wdata);
    chk("owner", owner, {31'b0, w});
    chk("wvalid_start", axi_wvalid, {31'b0, store});
    m_last = w;
    if (store) begin
      for (int n = 1; n <= wl; n++) begin
        if (n > 1) begin
          tick;
          chk("start_low", axi_start, 0);
          chk("wvalid_hold", axi_wvalid, 1);
        end
        chk("done_early_w", {i_done, d_done}, 0);
        if (n == wl) begin
          axi_wready = 1'b1;
          axi_done   = combo;
          axi_rdata  = rd;
        end else begin
          axi_done = (n == 1);
        end
      end
      tick;
      axi_wready = 1'b0;
      axi_done   = 1'b0;
      chk("wvalid_drop", axi_wvalid, 0);
    end
    if (!(store && combo)) begin
      for (int m = 1; m <= dl; m++) begin
        if (m > 1) tick;
        chk("done_early", {i_done, d_done}, 0);
        chk("start_once", axi_start, {31'b0, !store && m == 1});
        chk("wvalid_low", axi_wvalid, 0);
        if (m == dl) begin
          axi_done  = 1'b1;
          axi_rdata = rd;
        end
      end
      tick;
      axi_done = 1'b0;
    end
    if (!store) begin
      if (w) m_drdata = rd;
      else   m_irdata = rd;
    end
    chk("i_done", i_done, {31'b0, !w});
    chk("d_done", d_done, {31'b0, w});
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    tick;
    if (w) d_req = 1'b0;
    else   i_req = 1'b0;
    chk("done_single", {i_done, d_done}, 0);
    chk("idle_no_start", axi_start, 0);
  endtask

  initial begin
    resetn = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_rw = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; axi_wready = 1'b0; axi_rdata = 32'h0;
    axi_done = 1'b0; axi_busy = 1'b0;
    m_last = 1'b0; m_irdata = 32'h0; m_drdata = 32'h0; m_wdata = 32'h0;
    tick; tick;
    chk_reset_outputs("reset");
    resetn = 1'b1;
    tick;

    // inst read, done in cycle 4
    i_addr = 32'h1000; i_req = 1'b1;
    serve(1, 4, 1'b0, 32'hDEADBEEF);
    tick;

    // store with wvalid held three cycles
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h2004; d_wdata = 32'h12345678;
    serve(3, 2, 1'b0, 32'hA5A5A5A5);

    // two ties of loads
    for (int t = 0; t < 2; t++) begin
      i_req = 1'b1; d_req = 1'b1; d_rw = 1'b1;
      i_addr = 32'h3000 + t; d_addr = 32'h4000 + t; d_wdata = $urandom;
      serve(1, 2, 1'b0, $urandom);
      serve(1, 3, 1'b0, $urandom);
    end

    // busy holds off the launch
    axi_busy = 1'b1; d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h5000;
    for (int b = 0; b < 5; b++) begin
      tick;
      chk("busy_no_start", axi_start, 0);
    end
    axi_busy = 1'b0;
    serve(1, 2, 1'b0, 32'hCAFEF00D);

    // wready and done together
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h6000; d_wdata = 32'h0BADF00D;
    serve(2, 1, 1'b1, 32'h0);
    tick;
    chk("combo_idle", {i_done, d_done, axi_start}, 0);

    // reset in the middle of a read
    i_req = 1'b1; i_addr = 32'h7000;
    tick;
    chk("pre_abort_start", axi_start, 1);
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1; i_req = 1'b0;
    m_last = 1'b0; m_irdata = 32'h0; m_drdata = 32'h0; m_wdata = 32'h0;
    chk_reset_outputs("abort");
    tick;
    chk("abort_no_done", {i_done, d_done}, 0);
    i_req = 1'b1; i_addr = 32'h7100;
    serve(1, 2, 1'b0, 32'h13572468);

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      int pat;
      pat = $urandom_range(1, 3);
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_rw = $urandom_range(0, 1);
      i_req = pat[0]; d_req = pat[1];
      serve($urandom_range(1, 4), $urandom_range(2, 5), $urandom_range(0, 1), $urandom);
      if (pat == 3) serve($urandom_range(1, 4), $urandom_range(2, 5), $urandom_range(0, 1), $urandom);
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
